ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_clk_edge.sv | 23 ++
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM state encoding, default timing
// constants and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE
    } ps2_state_t;

    localparam int unsigned DEF_CLK_FREQ_HZ    = 100_000_000;
    localparam int unsigned DEF_INHIBIT_CYCLES = 12_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 2_000_000;

    // Falling-edge ordinals within a host-to-device frame
    localparam int unsigned       EDGE_W      = 4;
    localparam logic [EDGE_W-1:0] EDGE_PARITY = 4'd9;
    localparam logic [EDGE_W-1:0] EDGE_STOP   = 4'd10;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_clk_edge.sv
// Falling-edge detector for the debounced PS/2 clock line; the pulse is
// combinational from the registered previous level and the current level.
module ps2_clk_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    output logic o_fall
);

    logic r_prev;

    // Idle line level is high, so reset never fabricates a falling edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_ps2_clk;
        end
    end

    assign o_fall = r_prev & ~i_ps2_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked
// bit shifting on device falling edges, ack sampling and timeout abort.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       err
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    if (CLK_FREQ_HZ == 0 || INHIBIT_CYCLES == 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_host_tx: invalid timing parameters");
    end

    ps2_state_t        r_state;
    logic [INH_W-1:0]  r_inh;
    logic [TO_W-1:0]   r_to;
    logic [EDGE_W-1:0] r_edge;
    logic [7:0]        r_byte;
    logic              r_par;
    logic              r_ready;
    logic              r_clk_oe;
    logic              r_data_oe;
    logic              r_done;
    logic              r_err;

    logic              w_fall;
    logic [EDGE_W-1:0] w_edge_nxt;

    ps2_clk_edge u_clk_edge (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ps2_clk (ps2_clk_in),
        .o_fall    (w_fall)
    );

    assign w_edge_nxt = r_edge + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_inh     <= '0;
            r_to      <= '0;
            r_edge    <= '0;
            r_byte    <= '0;
            r_par     <= 1'b0;
            r_ready   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_ready   <= 1'b1;
                    if (tx_valid && r_ready) begin
                        r_byte   <= tx_data;
                        r_par    <= odd_parity(tx_data);
                        r_inh    <= '0;
                        r_ready  <= 1'b0;
                        r_clk_oe <= 1'b1;
                        r_state  <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (r_inh == INH_LAST) begin
                        r_data_oe <= 1'b1;
                        r_state   <= S_REQ;
                    end else begin
                        r_inh <= r_inh + 1'b1;
                    end
                end

                // Releasing the clock while data stays low is the start bit
                S_REQ: begin
                    r_edge   <= '0;
                    r_to     <= '0;
                    r_clk_oe <= 1'b0;
                    r_state  <= S_BITS;
                end

                S_BITS: begin
                    if (r_to == TO_LAST) begin
                        r_err     <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to <= r_to + 1'b1;
                        if (w_fall) begin
                            r_edge <= w_edge_nxt;
                            if (w_edge_nxt == EDGE_STOP) begin
                                r_data_oe <= 1'b0;
                                r_state   <= S_ACK;
                            end else if (w_edge_nxt == EDGE_PARITY) begin
                                r_data_oe <= ~r_par;
                            end else begin
                                r_data_oe <= ~r_byte[r_edge[2:0]];
                            end
                        end
                    end
                end

                S_ACK: begin
                    if (r_to == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_to <= r_to + 1'b1;
                        if (w_fall) begin
                            r_edge <= w_edge_nxt;
                            if (ps2_data_in) begin
                                r_err <= 1'b1;
                            end else begin
                                r_done <= 1'b1;
                            end
                            r_state <= S_WAIT_IDLE;
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (ps2_clk_in && ps2_data_in) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = r_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain line model plus a behavioural PS/2
// device that clocks frames, reads the bits the host puts on the data line and acks.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned TO   = 600;
    localparam int unsigned HALF = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       err;

    logic       drv_valid   = 1'b0;
    logic [7:0] drv_data    = 8'h00;
    logic       noise_en    = 1'b0;
    logic       noise_valid = 1'b0;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       frame_active = 1'b0;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;
    int unsigned done_total = 0;
    int unsigned err_total  = 0;
    int unsigned base_done;
    int unsigned base_err;

    assign tx_valid    = drv_valid | noise_valid;
    assign tx_data     = noise_en ? 8'hAA : drv_data;
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ    (100_000_000),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected line levels seen by the device: start, LSB-first data, odd parity, stop
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        int unsigned ones;
        ones = 0;
        f[0] = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += 32'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_total++;
            if (err)  err_total++;
            check("done_err_exclusive", 32'(done & err), 32'd0);
            if (!frame_active)
                check("lines_released_when_idle", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        end
    end

    task automatic start_frame(input logic [7:0] b, output int unsigned t_bits);
        int unsigned n;
        @(negedge clk);
        check("ready_before_send", 32'(tx_ready), 32'd1);
        base_done    = done_total;
        base_err     = err_total;
        frame_active = 1'b1;
        drv_data     = b;
        drv_valid    = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        drv_data  = ~b;
        check("inhibit_entry_rdy_clk_data", 32'({tx_ready, ps2_clk_oe, ps2_data_oe}), 32'b010);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_length", n, INH);
        check("request_both_low", 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
        @(negedge clk);
        check("bits_entry_clk_released_data_low", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
        t_bits = cyc;
    endtask

    task automatic dev_pulse();
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // Device side: reads each line value at the end of the low clock phase
    task automatic dev_frame(input logic ack_low, output logic [10:0] bits);
        int unsigned n;
        bits = '0;
        n = 0;
        while (!(ps2_clk_in && !ps2_data_in) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("device_sees_request", 32'(ps2_clk_in && !ps2_data_in), 32'd1);
        repeat (5) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int unsigned k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[k] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = ack_low;
        repeat (HALF / 2) @(negedge clk);
        dev_pulse();
        dev_data_low = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int unsigned exp_done, input int unsigned exp_err);
        int unsigned n;
        n = 0;
        while (!tx_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({name, "_ready_returns"}, 32'(tx_ready), 32'd1);
        check({name, "_done_pulses"}, done_total - base_done, exp_done);
        check({name, "_err_pulses"}, err_total - base_err, exp_err);
        frame_active = 1'b0;
    endtask

    task automatic send_acked(input string name, input logic [7:0] b, output logic [10:0] bits);
        int unsigned t_bits;
        start_frame(b, t_bits);
        dev_frame(1'b1, bits);
        check({name, "_frame_bits"}, 32'(bits), 32'(frame_model(b)));
        finish_frame(name, 1, 0);
    endtask

    initial begin
        logic [10:0] bits;
        int unsigned t_bits;
        int unsigned n;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({tx_ready, ps2_clk_oe, ps2_data_oe, done, err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_first_cycle_after_reset", 32'(tx_ready), 32'd1);
        repeat (3) @(negedge clk);

        // 0xED with 0xAA requests hammered on tx_valid during the frame
        fork
            begin
                start_frame(8'hED, t_bits);
                dev_frame(1'b1, bits);
            end
            begin
                repeat (3) @(negedge clk);
                noise_en = 1'b1;
                for (int unsigned i = 0; i < 20; i++) begin
                    noise_valid = ~noise_valid;
                    repeat (6) @(negedge clk);
                end
                noise_valid = 1'b0;
                noise_en    = 1'b0;
            end
        join
        check("ED_frame_bits", 32'(bits), 32'(frame_model(8'hED)));
        check("ED_data_literal", 32'(bits[8:1]), 32'hED);
        check("ED_parity_literal", 32'(bits[9]), 32'd1);
        check("ED_start_stop_literal", 32'({bits[10], bits[0]}), 32'b10);
        finish_frame("ED", 1, 0);

        send_acked("x01", 8'h01, bits);
        check("x01_parity_literal", 32'(bits[9]), 32'd0);
        send_acked("x00", 8'h00, bits);
        check("x00_parity_literal", 32'(bits[9]), 32'd1);

        start_frame(8'h5A, t_bits);
        dev_frame(1'b0, bits);
        check("nack_frame_bits", 32'(bits), 32'(frame_model(8'h5A)));
        finish_frame("nack", 0, 1);

        // Device never clocks: abort after exactly TO cycles in BITS/ACK
        start_frame(8'h3C, t_bits);
        n = 0;
        while (!err && n < TO + 50) begin
            n++;
            @(negedge clk);
        end
        check("timeout_latency", cyc - t_bits, TO);
        check("timeout_lines_and_ready", 32'({ps2_clk_oe, ps2_data_oe, tx_ready}), 32'b001);
        frame_active = 1'b0;
        repeat (5) @(negedge clk);
        check("timeout_err_pulses", err_total - base_err, 32'd1);
        check("timeout_done_pulses", done_total - base_done, 32'd0);

        // Reset during the low phase of falling edge 5 (bit 4 of 0x0F is 0)
        start_frame(8'h0F, t_bits);
        repeat (5) @(negedge clk);
        for (int unsigned k = 0; k < 4; k++) dev_pulse();
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        check("edge5_drives_bit4_low", 32'(ps2_data_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("reset_midframe_releases", 32'({ps2_clk_oe, ps2_data_oe}), 32'b00);
        rst          = 1'b0;
        dev_clk_low  = 1'b0;
        frame_active = 1'b0;
        repeat (30) @(negedge clk);
        check("aborted_no_done", done_total - base_done, 32'd0);
        check("aborted_no_err", err_total - base_err, 32'd0);

        send_acked("F4", 8'hF4, bits);
        check("F4_parity_literal", 32'(bits[9]), 32'd0);

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
